// File: rtl/uart_hex_pixel_loader_pkg.sv
// Purpose : shared definitions for the UART hex pixel loader.
//           ASCII code points recognised by the decoder and the
//           loader FSM state encoding.
// Ports   : none (package)
package uart_hex_pixel_loader_pkg;

  localparam logic [7:0] ASC_0    = 8'h30;
  localparam logic [7:0] ASC_9    = 8'h39;
  localparam logic [7:0] ASC_A_LO = 8'h61;
  localparam logic [7:0] ASC_F_LO = 8'h66;
  localparam logic [7:0] ASC_A_UP = 8'h41;
  localparam logic [7:0] ASC_F_UP = 8'h46;
  localparam logic [7:0] ASC_SP   = 8'h20;
  localparam logic [7:0] ASC_CR   = 8'h0D;
  localparam logic [7:0] ASC_LF   = 8'h0A;
  localparam logic [7:0] ASC_TAB  = 8'h09;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_EMIT    = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/uart_hex_pixel_loader_if.sv
// Purpose : byte stream from uart_rx plus the frame RAM write port.
// Signals : rx_data/rx_vld  byte and 1-cycle valid strobe from uart_rx
//           pix_data/pix_addr/pix_we  RAM write data, address, strobe
// Modports: master - the loader (consumes bytes, drives the RAM port)
//           slave  - the environment (drives bytes, observes writes)
interface uart_hex_pixel_loader_if #(
  parameter int PIX_W  = 24,
  parameter int ADDR_W = 17
);
  logic [7:0]        rx_data;
  logic              rx_vld;
  logic [PIX_W-1:0]  pix_data;
  logic [ADDR_W-1:0] pix_addr;
  logic              pix_we;

  modport master (
    input  rx_data, rx_vld,
    output pix_data, pix_addr, pix_we
  );

  modport slave (
    output rx_data, rx_vld,
    input  pix_data, pix_addr, pix_we
  );
endinterface

// File: rtl/uart_hex_pixel_loader_hex_ascii_decode.sv
// Purpose : combinational ASCII-hex classifier.
// Ports   : i_data    [7:0] received byte
//           o_nib     [3:0] nibble value (0 when not hex)
//           o_is_hex        byte is 0-9, a-f or A-F
//           o_is_ws         byte is space, CR, LF or TAB
module hex_ascii_decode
  import uart_hex_pixel_loader_pkg::*;
(
  input  logic [7:0] i_data,
  output logic [3:0] o_nib,
  output logic       o_is_hex,
  output logic       o_is_ws
);

  always_comb begin
    o_nib    = 4'h0;
    o_is_hex = 1'b0;
    o_is_ws  = 1'b0;
    if (i_data >= ASC_0 && i_data <= ASC_9) begin
      o_nib    = i_data[3:0];
      o_is_hex = 1'b1;
    end else if ((i_data >= ASC_A_LO && i_data <= ASC_F_LO) ||
                 (i_data >= ASC_A_UP && i_data <= ASC_F_UP)) begin
      // 'a'/'A' have low nibble 1, so value = low nibble + 9
      o_nib    = i_data[3:0] + 4'd9;
      o_is_hex = 1'b1;
    end else if (i_data == ASC_SP || i_data == ASC_CR ||
                 i_data == ASC_LF || i_data == ASC_TAB) begin
      o_is_ws  = 1'b1;
    end
  end

endmodule

// File: rtl/uart_hex_pixel_loader.sv
// Purpose : assembles ASCII-hex characters from uart_rx into NIBBLES-wide
//           pixels and writes FRAME_PIXELS words sequentially into frame RAM.
//           Illegal characters are flagged and counted, whitespace may be
//           skipped, and a restart switch aborts or re-arms a frame.
// Ports   : i_clk, i_rst      clock, synchronous active-high reset
//           bus (master)      rx byte stream in, RAM write port out
//           i_restart         level; leaves DONE or aborts current frame
//           o_frame_done      high from last write until restart
//           o_act_led         high for ACT_HOLD cycles after each write
//           o_byte_led  [7:0] last completed nibble pair
//           o_char_err        1-cycle pulse on illegal character
//           o_err_cnt   [7:0] saturating illegal-character count
//
// state      | meaning
// ST_COLLECT | gathering hex characters into the shift register
// ST_EMIT    | one cycle: register pixel, raise write strobe, advance address
// ST_DONE    | frame complete; characters ignored until restart
module uart_hex_pixel_loader
  import uart_hex_pixel_loader_pkg::*;
#(
  parameter int NIBBLES      = 6,
  parameter int FRAME_PIXELS = 129600,
  parameter int ADDR_W       = 17,
  parameter int SKIP_WS      = 1,
  parameter int ACT_HOLD     = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  uart_hex_pixel_loader_if.master bus,
  input  logic                    i_restart,
  output logic                    o_frame_done,
  output logic                    o_act_led,
  output logic [7:0]              o_byte_led,
  output logic                    o_char_err,
  output logic [7:0]              o_err_cnt
);

  localparam int PIX_W = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES < 2) ? 1 : $clog2(NIBBLES);
  localparam int ACT_W = $clog2(ACT_HOLD + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NIBBLES - 1);

  state_t             r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [PIX_W-1:0]   r_shift;
  logic [ADDR_W-1:0]  r_addr;
  logic [ADDR_W-1:0]  r_pix_addr;
  logic [PIX_W-1:0]   r_pix_data;
  logic               r_pix_we;
  logic               r_frame_done;
  logic [ACT_W-1:0]   r_act_cnt;
  logic [7:0]         r_byte_led;
  logic               r_char_err;
  logic [7:0]         r_err_cnt;

  logic [3:0]         w_nib;
  logic               w_is_hex;
  logic               w_is_ws;
  logic               w_take;
  logic               w_illegal;
  logic               w_last_nib;
  logic               w_pix_full;
  logic [PIX_W-1:0]   w_shift_next;

  hex_ascii_decode u_dec (
    .i_data   (bus.rx_data),
    .o_nib    (w_nib),
    .o_is_hex (w_is_hex),
    .o_is_ws  (w_is_ws)
  );

  // A character is consumed in COLLECT (unless restart overrides it) and
  // also during EMIT, so a back-to-back strobe starts the next pixel.
  always_comb begin
    w_take       = 1'b0;
    w_illegal    = 1'b0;
    w_last_nib   = 1'b0;
    w_pix_full   = 1'b0;
    w_shift_next = (r_shift << 4) | PIX_W'(w_nib);
    w_take       = bus.rx_vld &&
                   ((r_state == ST_COLLECT && !i_restart) || r_state == ST_EMIT);
    w_illegal    = !w_is_hex && !(w_is_ws && (SKIP_WS != 0));
    w_last_nib   = (r_idx == LAST_IDX);
    w_pix_full   = w_take && w_is_hex && w_last_nib;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_COLLECT;
      r_idx        <= '0;
      r_shift      <= '0;
      r_addr       <= '0;
      r_pix_addr   <= '0;
      r_pix_data   <= '0;
      r_pix_we     <= 1'b0;
      r_frame_done <= 1'b0;
      r_act_cnt    <= '0;
      r_byte_led   <= '0;
      r_char_err   <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_pix_we   <= 1'b0;
      r_char_err <= 1'b0;

      if (r_pix_we)
        r_act_cnt <= ACT_W'(ACT_HOLD);
      else if (r_act_cnt != '0)
        r_act_cnt <= r_act_cnt - ACT_W'(1);

      if (w_take) begin
        if (w_is_hex) begin
          r_shift <= w_shift_next;
          r_idx   <= w_last_nib ? '0 : r_idx + IDX_W'(1);
          // odd index before this char means a nibble pair just closed
          if (r_idx[0])
            r_byte_led <= {r_shift[3:0], w_nib};
          else if (w_last_nib)
            r_byte_led <= {4'h0, w_nib};
        end else if (w_illegal) begin
          r_char_err <= 1'b1;
          if (r_err_cnt != 8'hFF)
            r_err_cnt <= r_err_cnt + 8'd1;
          r_idx   <= '0;
          r_shift <= '0;
        end
      end

      case (r_state)
        ST_COLLECT: begin
          if (i_restart) begin
            r_idx   <= '0;
            r_addr  <= '0;
            r_shift <= '0;
          end else if (w_pix_full) begin
            r_state <= ST_EMIT;
          end
        end
        ST_EMIT: begin
          r_pix_data <= r_shift;
          r_pix_addr <= r_addr;
          r_pix_we   <= 1'b1;
          if (r_addr == LAST_ADDR) begin
            r_addr       <= '0;
            r_frame_done <= 1'b1;
            r_state      <= ST_DONE;
          end else begin
            r_addr  <= r_addr + ADDR_W'(1);
            // only reachable with single-nibble pixels
            r_state <= w_pix_full ? ST_EMIT : ST_COLLECT;
          end
        end
        ST_DONE: begin
          if (i_restart) begin
            r_state      <= ST_COLLECT;
            r_frame_done <= 1'b0;
            r_idx        <= '0;
            r_shift      <= '0;
          end
        end
        default: r_state <= ST_COLLECT;
      endcase
    end
  end

  assign bus.pix_data  = r_pix_data;
  assign bus.pix_addr  = r_pix_addr;
  assign bus.pix_we    = r_pix_we;
  assign o_frame_done  = r_frame_done;
  assign o_act_led     = (r_act_cnt != '0);
  assign o_byte_led    = r_byte_led;
  assign o_char_err    = r_char_err;
  assign o_err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_uart_hex_pixel_loader.sv
module tb_uart_hex_pixel_loader;
  localparam int NIB = 6;
  localparam int FP  = 4;
  localparam int AW  = 17;
  localparam int AH  = 16;
  localparam int PW  = 4 * NIB;

  logic       clk = 1'b0;
  logic       rst;
  logic       restart;
  logic       frame_done;
  logic       act_led;
  logic [7:0] byte_led;
  logic       char_err;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  uart_hex_pixel_loader_if #(.PIX_W(PW), .ADDR_W(AW)) bus ();

  uart_hex_pixel_loader #(
    .NIBBLES(NIB), .FRAME_PIXELS(FP), .ADDR_W(AW), .SKIP_WS(1), .ACT_HOLD(AH)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .bus          (bus),
    .i_restart    (restart),
    .o_frame_done (frame_done),
    .o_act_led    (act_led),
    .o_byte_led   (byte_led),
    .o_char_err   (char_err),
    .o_err_cnt    (err_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_err_pulses = 0;
  logic [AW-1:0] q_addr[$];
  logic [PW-1:0] q_data[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_pix(input logic [AW-1:0] a, input logic [PW-1:0] d);
    q_addr.push_back(a);
    q_data.push_back(d);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (char_err === 1'b1) n_err_pulses++;
    if (bus.pix_we === 1'b1) begin
      if (q_data.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0h data %0h, expected no write", bus.pix_addr, bus.pix_data);
      end else begin
        logic [AW-1:0] ea;
        logic [PW-1:0] ed;
        ea = q_addr.pop_front();
        ed = q_data.pop_front();
        chk("write_addr", 32'(bus.pix_addr), 32'(ea));
        chk("write_data", 32'(bus.pix_data), 32'(ed));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_char(input logic [7:0] c);
    @(negedge clk);
    bus.rx_data = c;
    bus.rx_vld  = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_vld  = 1'b0;
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      send_char(s[i]);
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
  endtask

  initial begin
    int seen;
    int cnt;
    rst         = 1'b1;
    restart     = 1'b0;
    bus.rx_vld  = 1'b0;
    bus.rx_data = 8'h00;
    idle(3);
    chk("rst_pix_we", 32'(bus.pix_we), 0);
    chk("rst_pix_data", 32'(bus.pix_data), 0);
    chk("rst_pix_addr", 32'(bus.pix_addr), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_act_led", 32'(act_led), 0);
    chk("rst_byte_led", 32'(byte_led), 0);
    chk("rst_char_err", 32'(char_err), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    rst = 1'b0;
    idle(2);

    // first pixel, byte_led sequence and write latency
    expect_pix(0, 24'hFF8000);
    send_char("f"); idle(1);
    send_char("f");
    chk("byte_led_ff", 32'(byte_led), 32'h0FF);
    idle(1);
    send_char("8"); idle(1);
    send_char("0");
    chk("byte_led_80", 32'(byte_led), 32'h080);
    idle(1);
    send_char("0"); idle(1);
    send_char("0");
    chk("byte_led_00", 32'(byte_led), 32'h000);
    chk("we_not_early", 32'(bus.pix_we), 0);
    idle(1);
    chk("we_latency", 32'(bus.pix_we), 1);
    chk("act_led_before_load", 32'(act_led), 0);
    idle(3);
    chk("act_led_on", 32'(act_led), 1);

    // mixed case with CR/LF framing
    expect_pix(1, 24'hA1B2C3);
    send_str("\r\nA1b2C3\r\n", 1);
    idle(3);
    chk("no_err_pulse_mixed", 32'(n_err_pulses), 0);
    chk("err_cnt_mixed", 32'(err_cnt), 0);

    // illegal character discards partial pixel
    expect_pix(2, 24'h456789);
    send_str("12g456789abc", 1);
    idle(3);
    chk("err_pulse_g", 32'(n_err_pulses), 1);
    chk("err_cnt_g", 32'(err_cnt), 1);

    // abort with "abc" pending at addr 3: frame restarts at addr 0
    pulse_restart();
    expect_pix(0, 24'h123456);
    send_str("123456", 1);
    expect_pix(1, 24'h0000AA);
    send_str("00 00\tAA", 1);
    expect_pix(2, 24'hBBBBBB);
    send_str("BBBBBB", 1);
    chk("frame_not_done", 32'(frame_done), 0);
    expect_pix(3, 24'hCCCCCC);
    send_str("CCCCCC", 1);
    idle(3);
    chk("frame_done", 32'(frame_done), 1);

    // ignored while done
    send_str("zz12", 1);
    idle(3);
    chk("done_err_cnt", 32'(err_cnt), 1);
    chk("done_held", 32'(frame_done), 1);
    pulse_restart();
    chk("restart_clears_done", 32'(frame_done), 0);

    // back-to-back strobes, 7th char lands in EMIT
    expect_pix(0, 24'h012345);
    expect_pix(1, 24'h6789AB);
    send_str("0123456789AB", 0);
    seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      @(negedge clk);
      if (bus.pix_we === 1'b1) seen = 1;
    end
    chk("last_we_seen", 32'(seen), 1);
    cnt = 0;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      if (act_led === 1'b1) cnt++;
      else break;
    end
    chk("act_hold_len", 32'(cnt), AH);

    // reset mid-frame
    send_str("777", 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_err_cnt", 32'(err_cnt), 0);
    chk("mid_rst_byte_led", 32'(byte_led), 0);
    chk("mid_rst_pix_addr", 32'(bus.pix_addr), 0);
    chk("mid_rst_pix_data", 32'(bus.pix_data), 0);
    rst = 1'b0;
    idle(1);
    expect_pix(0, 24'h135790);
    send_str("135790", 1);
    idle(5);

    chk("all_writes_seen", 32'(q_data.size()), 0);
    chk("total_err_pulses", 32'(n_err_pulses), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
